debug_port_ctrl: RTL and testbench

Controller behind the external 8-bit debug port (PIN_DEBUG_DATA/ADDR/WRN/RDN/STOP). It synchronises the asynchronous host strobes and decodes a small register file. A state machine sequences the CPU core through run, stop, single-step and halted memory access. It sits between the top-level pads and the core's stop handshake and memory bus master port.

---
 rtl/debug_port_ctrl_pkg.sv | 44 ++++
 rtl/debug_strobe_sync.sv | 39 +++
 rtl/debug_port_ctrl.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_debug_port_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_port_ctrl_pkg.sv
// Shared constants for the debug port controller: register addresses, command codes,
// STATUS bit positions and the sequencer state encoding.
package debug_port_ctrl_pkg;

    // Register select values on DEBUG_ADDR
    localparam logic [2:0] DBG_REG_CMD     = 3'd0;  // write side of address 0
    localparam logic [2:0] DBG_REG_STATUS  = 3'd0;  // read side of address 0
    localparam logic [2:0] DBG_REG_ADDR_LO = 3'd1;
    localparam logic [2:0] DBG_REG_ADDR_HI = 3'd2;
    localparam logic [2:0] DBG_REG_DATA_LO = 3'd3;
    localparam logic [2:0] DBG_REG_DATA_HI = 3'd4;
    localparam logic [2:0] DBG_REG_BP_LO   = 3'd5;
    localparam logic [2:0] DBG_REG_BP_HI   = 3'd6;

    // Command codes written to DBG_REG_CMD
    localparam logic [7:0] DBG_CMD_STOP       = 8'h01;
    localparam logic [7:0] DBG_CMD_RUN        = 8'h02;
    localparam logic [7:0] DBG_CMD_STEP       = 8'h03;
    localparam logic [7:0] DBG_CMD_MEM_RD     = 8'h04;
    localparam logic [7:0] DBG_CMD_MEM_WR     = 8'h05;
    localparam logic [7:0] DBG_CMD_MEM_RD_INC = 8'h06;
    localparam logic [7:0] DBG_CMD_MEM_WR_INC = 8'h07;

    // STATUS bit positions
    localparam int unsigned STATUS_HALTED_BIT = 0;
    localparam int unsigned STATUS_BP_HIT_BIT = 2;
    localparam int unsigned STATUS_ERR_BIT    = 3;
    localparam int unsigned STATUS_BUSY_BIT   = 4;

    typedef enum logic [2:0] {
        StRun      = 3'd0,
        StStopping = 3'd1,
        StHalted   = 3'd2,
        StStepping = 3'd3,
        StMem      = 3'd4
    } dbg_state_e;

    // Memory commands carry their direction in bit 0 and auto-increment in bit 1.
    function automatic logic is_mem_cmd(input logic [7:0] cmd);
        return (cmd == DBG_CMD_MEM_RD) || (cmd == DBG_CMD_MEM_WR) ||
               (cmd == DBG_CMD_MEM_RD_INC) || (cmd == DBG_CMD_MEM_WR_INC);
    endfunction

endpackage

// File: rtl/debug_strobe_sync.sv
// Synchroniser and edge detector for one active-low asynchronous host strobe.
// Ports:
//   clk_i      system clock
//   rst_i      synchronous reset, active-high
//   strobe_ni  asynchronous active-low strobe from the pad
//   level_o    synchronised strobe level
//   fall_o     one-cycle pulse on the synchronised falling edge
//   rise_o     one-cycle pulse on the synchronised rising edge
// STAGES must be at least 2.
module debug_strobe_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic strobe_ni,
    output logic level_o,
    output logic fall_o,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Reset to the idle (high) level so leaving reset never looks like a strobe edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], strobe_ni};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign fall_o  = prev_q & ~sync_q[STAGES-1];
    assign rise_o  = ~prev_q & sync_q[STAGES-1];

endmodule

// File: rtl/debug_port_ctrl.sv
// Debug port controller: synchronises the host WRN/RDN strobes, decodes the 8-bit
// register file and sequences the CPU through run / stop / single-step / halted
// memory access.
// Ports:
//   CLK, RESET                       clock, synchronous active-high reset
//   DEBUG_DIN/DOUT/OE/ADDR/WRN/RDN   host side of the debug pad
//   DEBUG_STOP                       CPU halted under debug control
//   CPU_STOP_REQ, CPU_STOPPED        core stop handshake
//   MEM_REQ/WR/ADDR/DOUT/DIN/ACK     bus master port
//   CPU_PC                           core PC, breakpoint compare only
// Optional feature: define DEBUG_BREAKPOINT_EN for the PC breakpoint (BP_LO/BP_HI).
module debug_port_ctrl
    import debug_port_ctrl_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ADDR_STEP   = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  DEBUG_DIN,
    output logic [7:0]  DEBUG_DOUT,
    output logic        DEBUG_OE,
    input  logic [2:0]  DEBUG_ADDR,
    input  logic        DEBUG_WRN,
    input  logic        DEBUG_RDN,
    output logic        DEBUG_STOP,
    output logic        CPU_STOP_REQ,
    input  logic        CPU_STOPPED,
    output logic        MEM_REQ,
    output logic        MEM_WR,
    output logic [15:0] MEM_ADDR,
    output logic [15:0] MEM_DOUT,
    input  logic [15:0] MEM_DIN,
    input  logic        MEM_ACK,
    input  logic [15:0] CPU_PC
);

    localparam logic [15:0] AddrInc = 16'(ADDR_STEP);

    logic wr_level, wr_fall, wr_rise;
    logic rd_level, rd_fall, rd_rise;

    debug_strobe_sync #(.STAGES(SYNC_STAGES)) u_wr_sync (
        .clk_i    (CLK),
        .rst_i    (RESET),
        .strobe_ni(DEBUG_WRN),
        .level_o  (wr_level),
        .fall_o   (wr_fall),
        .rise_o   (wr_rise)
    );

    debug_strobe_sync #(.STAGES(SYNC_STAGES)) u_rd_sync (
        .clk_i    (CLK),
        .rst_i    (RESET),
        .strobe_ni(DEBUG_RDN),
        .level_o  (rd_level),
        .fall_o   (rd_fall),
        .rise_o   (rd_rise)
    );

    logic unused_strobe;
    assign unused_strobe = wr_fall ^ rd_level;

    dbg_state_e state_q, state_d;
    logic [7:0] addr_lo_q, addr_lo_d, addr_hi_q, addr_hi_d;
    logic [7:0] data_lo_q, data_lo_d, data_hi_q, data_hi_d;
    logic       err_q, err_d, err_set;
    logic       mem_wr_q, mem_wr_d, mem_inc_q, mem_inc_d;
    logic [7:0] dout_q, dout_d;
    logic       oe_q, oe_d;
    logic [2:0] wr_addr_q, rd_addr_q;
    logic [7:0] wr_data_q;
    logic       wr_go_q;
    logic       busy, cmd_write, reg_write, bp_hit;
    logic [7:0] status, rd_mux;
    logic [15:0] next_addr;

`ifdef DEBUG_BREAKPOINT_EN
    logic [7:0] bp_lo_q, bp_lo_d, bp_hi_q, bp_hi_d;
    logic       bp_hit_q, bp_hit_d;
    logic       bp_match;
    logic       unused_pc;

    // BP_HI[7] enables the compare; the match covers PC bits 14:0.
    assign bp_match  = bp_hi_q[7] && (CPU_PC[14:0] == {bp_hi_q[6:0], bp_lo_q});
    assign unused_pc = CPU_PC[15];
    assign bp_hit    = bp_hit_d;
`else
    logic [15:0] unused_pc;
    assign unused_pc = CPU_PC;
    assign bp_hit    = 1'b0;
`endif

    // Host write capture: DIN/ADDR track the pad while the write strobe is held low.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_go_q   <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            if (!wr_level) begin
                wr_addr_q <= DEBUG_ADDR;
                wr_data_q <= DEBUG_DIN;
            end
            wr_go_q   <= wr_rise;
            rd_addr_q <= DEBUG_ADDR;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= StRun;
            addr_lo_q <= '0;
            addr_hi_q <= '0;
            data_lo_q <= '0;
            data_hi_q <= '0;
            err_q     <= 1'b0;
            mem_wr_q  <= 1'b0;
            mem_inc_q <= 1'b0;
            dout_q    <= '0;
            oe_q      <= 1'b0;
`ifdef DEBUG_BREAKPOINT_EN
            bp_lo_q   <= '0;
            bp_hi_q   <= '0;
            bp_hit_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_lo_q <= addr_lo_d;
            addr_hi_q <= addr_hi_d;
            data_lo_q <= data_lo_d;
            data_hi_q <= data_hi_d;
            err_q     <= err_d;
            mem_wr_q  <= mem_wr_d;
            mem_inc_q <= mem_inc_d;
            dout_q    <= dout_d;
            oe_q      <= oe_d;
`ifdef DEBUG_BREAKPOINT_EN
            bp_lo_q   <= bp_lo_d;
            bp_hi_q   <= bp_hi_d;
            bp_hit_q  <= bp_hit_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_lo_d = addr_lo_q;
        addr_hi_d = addr_hi_q;
        data_lo_d = data_lo_q;
        data_hi_d = data_hi_q;
        err_set   = 1'b0;
        err_d     = err_q;
        mem_wr_d  = mem_wr_q;
        mem_inc_d = mem_inc_q;
        dout_d    = dout_q;
        oe_d      = oe_q;
        status    = 8'h00;
        rd_mux    = 8'h00;
        next_addr = {addr_hi_q, addr_lo_q} + AddrInc;
`ifdef DEBUG_BREAKPOINT_EN
        bp_lo_d   = bp_lo_q;
        bp_hi_d   = bp_hi_q;
        bp_hit_d  = bp_hit_q;
`endif

        busy      = (state_q == StStopping) || (state_q == StStepping) || (state_q == StMem);
        cmd_write = wr_go_q && (wr_addr_q == DBG_REG_CMD);
        reg_write = wr_go_q && !busy;

        // Autonomous transitions driven by the core and the bus.
        unique case (state_q)
            StRun: begin
`ifdef DEBUG_BREAKPOINT_EN
                // Only checked in RUN, so a STEP off a breakpoint address is never caught.
                if (bp_match) begin
                    state_d  = StStopping;
                    bp_hit_d = 1'b1;
                end
`endif
            end
            StStopping: if (CPU_STOPPED) state_d = StHalted;
            // Wait for the core to actually leave stop before asking it to stop again,
            // otherwise it would never execute the stepped instruction.
            StStepping: if (!CPU_STOPPED) state_d = StStopping;
            StMem: begin
                if (MEM_ACK) begin
                    state_d = StHalted;
                    if (!mem_wr_q) begin
                        data_lo_d = MEM_DIN[7:0];
                        data_hi_d = MEM_DIN[15:8];
                    end
                    if (mem_inc_q) begin
                        addr_lo_d = next_addr[7:0];
                        addr_hi_d = next_addr[15:8];
                    end
                end
            end
            StHalted: ;
            default: state_d = StRun;
        endcase

        // Commands. Busy states only ever change via the autonomous paths above.
        if (cmd_write) begin
            if (busy) begin
                err_set = 1'b1;
            end else if (wr_data_q == DBG_CMD_STOP) begin
                if (state_q == StRun) state_d = StStopping;
            end else if (wr_data_q == DBG_CMD_RUN) begin
                state_d = StRun;
`ifdef DEBUG_BREAKPOINT_EN
                bp_hit_d = 1'b0;
`endif
            end else if (wr_data_q == DBG_CMD_STEP) begin
                if (state_q == StHalted) begin
                    state_d = StStepping;
`ifdef DEBUG_BREAKPOINT_EN
                    bp_hit_d = 1'b0;
`endif
                end else begin
                    err_set = 1'b1;
                end
            end else if (is_mem_cmd(wr_data_q)) begin
                if (state_q == StHalted) begin
                    state_d   = StMem;
                    mem_wr_d  = wr_data_q[0];
                    mem_inc_d = wr_data_q[1];
                end else begin
                    err_set = 1'b1;
                end
            end else begin
                err_set = 1'b1;
            end
        end

        if (reg_write) begin
            case (wr_addr_q)
                DBG_REG_ADDR_LO: addr_lo_d = wr_data_q;
                DBG_REG_ADDR_HI: addr_hi_d = wr_data_q;
                DBG_REG_DATA_LO: data_lo_d = wr_data_q;
                DBG_REG_DATA_HI: data_hi_d = wr_data_q;
`ifdef DEBUG_BREAKPOINT_EN
                DBG_REG_BP_LO:   bp_lo_d   = wr_data_q;
                DBG_REG_BP_HI:   bp_hi_d   = wr_data_q;
`endif
                default: ;
            endcase
        end

        err_d = err_q | err_set;

        // Read mux sees next-state values so a coincident write is visible.
        status[STATUS_BUSY_BIT]   = (state_d == StStopping) || (state_d == StStepping) ||
                                    (state_d == StMem);
        status[STATUS_ERR_BIT]    = err_d;
        status[STATUS_BP_HIT_BIT] = bp_hit;
        status[STATUS_HALTED_BIT] = (state_d == StHalted) || (state_d == StMem);

        case (rd_addr_q)
            DBG_REG_STATUS:  rd_mux = status;
            DBG_REG_ADDR_LO: rd_mux = addr_lo_d;
            DBG_REG_ADDR_HI: rd_mux = addr_hi_d;
            DBG_REG_DATA_LO: rd_mux = data_lo_d;
            DBG_REG_DATA_HI: rd_mux = data_hi_d;
`ifdef DEBUG_BREAKPOINT_EN
            DBG_REG_BP_LO:   rd_mux = bp_lo_d;
            DBG_REG_BP_HI:   rd_mux = bp_hi_d;
`endif
            default:         rd_mux = 8'h00;
        endcase

        if (rd_fall) begin
            dout_d = rd_mux;
            oe_d   = 1'b1;
            if (rd_addr_q == DBG_REG_STATUS) err_d = 1'b0;
        end else if (rd_rise) begin
            oe_d = 1'b0;
        end
    end

    assign DEBUG_DOUT   = dout_q;
    assign DEBUG_OE     = oe_q;
    assign DEBUG_STOP   = (state_q == StHalted) || (state_q == StMem);
    assign CPU_STOP_REQ = (state_q == StStopping) || (state_q == StHalted) || (state_q == StMem);
    assign MEM_REQ      = (state_q == StMem);
    assign MEM_WR       = MEM_REQ & mem_wr_q;
    assign MEM_ADDR     = {addr_hi_q, addr_lo_q};
    assign MEM_DOUT     = {data_hi_q, data_lo_q};

endmodule

// File: tb/tb_debug_port_ctrl.sv
module tb_debug_port_ctrl;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [7:0]  DEBUG_DIN = 8'h00;
    logic [7:0]  DEBUG_DOUT;
    logic        DEBUG_OE;
    logic [2:0]  DEBUG_ADDR = 3'd0;
    logic        DEBUG_WRN = 1'b1;
    logic        DEBUG_RDN = 1'b1;
    logic        DEBUG_STOP;
    logic        CPU_STOP_REQ;
    logic        CPU_STOPPED = 1'b0;
    logic        MEM_REQ;
    logic        MEM_WR;
    logic [15:0] MEM_ADDR;
    logic [15:0] MEM_DOUT;
    logic [15:0] MEM_DIN = 16'h0000;
    logic        MEM_ACK = 1'b0;
    logic [15:0] CPU_PC = 16'h0000;

    always #5 CLK = ~CLK;

    debug_port_ctrl #(.SYNC_STAGES(2), .ADDR_STEP(2)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .DEBUG_DIN   (DEBUG_DIN),
        .DEBUG_DOUT  (DEBUG_DOUT),
        .DEBUG_OE    (DEBUG_OE),
        .DEBUG_ADDR  (DEBUG_ADDR),
        .DEBUG_WRN   (DEBUG_WRN),
        .DEBUG_RDN   (DEBUG_RDN),
        .DEBUG_STOP  (DEBUG_STOP),
        .CPU_STOP_REQ(CPU_STOP_REQ),
        .CPU_STOPPED (CPU_STOPPED),
        .MEM_REQ     (MEM_REQ),
        .MEM_WR      (MEM_WR),
        .MEM_ADDR    (MEM_ADDR),
        .MEM_DOUT    (MEM_DOUT),
        .MEM_DIN     (MEM_DIN),
        .MEM_ACK     (MEM_ACK),
        .CPU_PC      (CPU_PC)
    );

    int tests = 0;
    int fails = 0;

    // CPU model: stops 3 cycles after a request, leaves stop rel_delay cycles after release.
    int rel_delay = 5;
    int req_cnt = 0;
    int rel_cnt = 0;
    always @(posedge CLK) begin
        if (RESET) begin
            CPU_STOPPED <= 1'b0;
            req_cnt     <= 0;
            rel_cnt     <= 0;
        end else if (CPU_STOP_REQ) begin
            rel_cnt <= 0;
            if (!CPU_STOPPED) begin
                if (req_cnt == 2) begin
                    CPU_STOPPED <= 1'b1;
                    req_cnt     <= 0;
                end else begin
                    req_cnt <= req_cnt + 1;
                end
            end
        end else begin
            req_cnt <= 0;
            if (CPU_STOPPED) begin
                if (rel_cnt == rel_delay - 1) begin
                    CPU_STOPPED <= 1'b0;
                    rel_cnt     <= 0;
                end else begin
                    rel_cnt <= rel_cnt + 1;
                end
            end
        end
    end

    // Bus model: acks bus_delay cycles into a request, recording what it saw.
    int          bus_delay = 2;
    int          bus_cnt = 0;
    logic [15:0] bus_rdata = 16'h0000;
    int          mem_acks = 0;
    logic [15:0] last_addr = 16'h0000;
    logic [15:0] last_dout = 16'h0000;
    logic        last_wr = 1'b0;
    always @(posedge CLK) begin
        if (RESET || !MEM_REQ) begin
            bus_cnt <= 0;
            MEM_ACK <= 1'b0;
        end else if (MEM_ACK) begin
            MEM_ACK <= 1'b0;
        end else if (bus_cnt >= bus_delay) begin
            MEM_ACK   <= 1'b1;
            MEM_DIN   <= bus_rdata;
            bus_cnt   <= 0;
            mem_acks  <= mem_acks + 1;
            last_addr <= MEM_ADDR;
            last_dout <= MEM_DOUT;
            last_wr   <= MEM_WR;
        end else begin
            bus_cnt <= bus_cnt + 1;
        end
    end

    // Event monitors
    logic stop_prev = 1'b0, req_prev = 1'b0, cpu_prev = 1'b0;
    int   stop_falls = 0, early_req = 0, cpu_releases = 0, mem_req_cycles = 0;
    always @(posedge CLK) begin
        stop_prev <= DEBUG_STOP;
        req_prev  <= CPU_STOP_REQ;
        cpu_prev  <= CPU_STOPPED;
        if (stop_prev && !DEBUG_STOP) stop_falls <= stop_falls + 1;
        if (!req_prev && CPU_STOP_REQ && CPU_STOPPED) early_req <= early_req + 1;
        if (cpu_prev && !CPU_STOPPED) cpu_releases <= cpu_releases + 1;
        if (MEM_REQ) mem_req_cycles <= mem_req_cycles + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic dbg_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge CLK);
        DEBUG_ADDR = a;
        DEBUG_DIN  = d;
        DEBUG_WRN  = 1'b0;
        repeat (4) @(negedge CLK);
        DEBUG_WRN = 1'b1;
        repeat (5) @(negedge CLK);
    endtask

    task automatic dbg_read(input logic [2:0] a, output logic [7:0] d, output logic oe);
        @(negedge CLK);
        DEBUG_ADDR = a;
        DEBUG_RDN  = 1'b0;
        repeat (5) @(negedge CLK);
        d  = DEBUG_DOUT;
        oe = DEBUG_OE;
        DEBUG_RDN = 1'b1;
        repeat (5) @(negedge CLK);
    endtask

    task automatic read_check(input string name, input logic [2:0] a, input logic [7:0] exp);
        logic [7:0] d;
        logic       oe;
        dbg_read(a, d, oe);
        check16(name, 16'(d), 16'(exp));
    endtask

    task automatic wait_debug_stop(input logic val, input string name);
        int n = 0;
        while (DEBUG_STOP !== val && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check_bit(name, DEBUG_STOP, val);
        repeat (2) @(negedge CLK);
    endtask

    task automatic wait_acks(input int target, input string name);
        int n = 0;
        while (mem_acks < target && n < 300) begin
            @(negedge CLK);
            n++;
        end
        check16(name, 16'(mem_acks), 16'(target));
        repeat (3) @(negedge CLK);
    endtask

    typedef struct {
        logic [2:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [7:0] rd;
        logic       oe;
        int         f0, c0, e0, a0, m0;

        vecs[0] = '{3'd1, 8'hA5, 8'hA5};
        vecs[1] = '{3'd2, 8'h3C, 8'h3C};
        vecs[2] = '{3'd3, 8'h0F, 8'h0F};
        vecs[3] = '{3'd4, 8'hF0, 8'hF0};
`ifdef DEBUG_BREAKPOINT_EN
        vecs[4] = '{3'd5, 8'h77, 8'h77};
        vecs[5] = '{3'd6, 8'h11, 8'h11};
`else
        vecs[4] = '{3'd5, 8'h77, 8'h00};
        vecs[5] = '{3'd6, 8'h11, 8'h00};
`endif
        vecs[6] = '{3'd7, 8'hFF, 8'h00};
        vecs[7] = '{3'd1, 8'h5A, 8'h5A};

        // Reset
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        check_bit("reset DEBUG_STOP", DEBUG_STOP, 1'b0);
        check_bit("reset CPU_STOP_REQ", CPU_STOP_REQ, 1'b0);
        check_bit("reset MEM_REQ", MEM_REQ, 1'b0);
        check_bit("reset DEBUG_OE", DEBUG_OE, 1'b0);
        check16("reset DEBUG_DOUT", 16'(DEBUG_DOUT), 16'h0000);
        dbg_read(3'd0, rd, oe);
        check16("reset STATUS", 16'(rd), 16'h0000);
        check_bit("OE during read", oe, 1'b1);
        check_bit("OE after read", DEBUG_OE, 1'b0);

        // Register write / readback table
        for (int i = 0; i < 8; i++) begin
            dbg_write(vecs[i].addr, vecs[i].wdata);
            read_check($sformatf("vec%0d reg%0d readback", i, vecs[i].addr), vecs[i].addr,
                       vecs[i].exp);
        end
        read_check("STATUS after table", 3'd0, 8'h00);

        // Memory command while running is an error
        m0 = mem_req_cycles;
        dbg_write(3'd0, 8'h04);
        read_check("RUN MEM_RD STATUS", 3'd0, 8'h08);
        check16("RUN MEM_RD no MEM_REQ", 16'(mem_req_cycles - m0), 16'h0000);
        read_check("STATUS err cleared", 3'd0, 8'h00);
        dbg_write(3'd0, 8'h09);
        read_check("bad cmd STATUS", 3'd0, 8'h08);

        // Write and read landing in the same cycle: read sees the new value
        @(negedge CLK);
        DEBUG_ADDR = 3'd1;
        DEBUG_DIN  = 8'h6B;
        DEBUG_WRN  = 1'b0;
        repeat (4) @(negedge CLK);
        DEBUG_WRN = 1'b1;
        @(negedge CLK);
        DEBUG_RDN = 1'b0;
        repeat (5) @(negedge CLK);
        check16("overlap read post-write", 16'(DEBUG_DOUT), 16'h006B);
        DEBUG_RDN = 1'b1;
        repeat (5) @(negedge CLK);

        // STOP
        dbg_write(3'd0, 8'h01);
        wait_debug_stop(1'b1, "STOP DEBUG_STOP");
        check_bit("STOP CPU_STOP_REQ", CPU_STOP_REQ, 1'b1);
        read_check("halted STATUS", 3'd0, 8'h01);
        dbg_write(3'd0, 8'h01);
        read_check("STOP while halted no-op", 3'd0, 8'h01);

        // MEM_RD_INC
        dbg_write(3'd1, 8'h34);
        dbg_write(3'd2, 8'h12);
        bus_rdata = 16'hBEEF;
        a0 = mem_acks;
        dbg_write(3'd0, 8'h06);
        wait_acks(a0 + 1, "MEM_RD_INC ack");
        check16("MEM_RD_INC MEM_ADDR", last_addr, 16'h1234);
        check_bit("MEM_RD_INC MEM_WR", last_wr, 1'b0);
        read_check("MEM_RD_INC DATA_LO", 3'd3, 8'hEF);
        read_check("MEM_RD_INC DATA_HI", 3'd4, 8'hBE);
        read_check("MEM_RD_INC ADDR_LO", 3'd1, 8'h36);
        read_check("MEM_RD_INC ADDR_HI", 3'd2, 8'h12);
        read_check("MEM_RD_INC STATUS", 3'd0, 8'h01);

        // MEM_WR_INC with address wrap
        dbg_write(3'd3, 8'h55);
        dbg_write(3'd4, 8'hAA);
        dbg_write(3'd1, 8'hFE);
        dbg_write(3'd2, 8'hFF);
        a0 = mem_acks;
        dbg_write(3'd0, 8'h07);
        wait_acks(a0 + 1, "MEM_WR_INC ack");
        check16("MEM_WR_INC MEM_ADDR", last_addr, 16'hFFFE);
        check_bit("MEM_WR_INC MEM_WR", last_wr, 1'b1);
        check16("MEM_WR_INC MEM_DOUT", last_dout, 16'hAA55);
        read_check("wrap ADDR_LO", 3'd1, 8'h00);
        read_check("wrap ADDR_HI", 3'd2, 8'h00);
        read_check("MEM_WR keeps DATA_LO", 3'd3, 8'h55);

        // Single step
        f0 = stop_falls;
        c0 = cpu_releases;
        e0 = early_req;
        dbg_write(3'd0, 8'h03);
        wait_debug_stop(1'b1, "STEP re-halt");
        check16("STEP DEBUG_STOP low pulses", 16'(stop_falls - f0), 16'd1);
        check16("STEP core left stop once", 16'(cpu_releases - c0), 16'd1);
        check16("STEP no stop req before release", 16'(early_req - e0), 16'd0);
        check_bit("STEP CPU_STOP_REQ", CPU_STOP_REQ, 1'b1);
        read_check("STEP STATUS", 3'd0, 8'h01);

        // Command and register write while busy
        bus_delay = 80;
        bus_rdata = 16'h1357;
        a0 = mem_acks;
        dbg_write(3'd0, 8'h04);
        read_check("busy STATUS", 3'd0, 8'h11);
        dbg_write(3'd0, 8'h02);
        dbg_write(3'd1, 8'h99);
        read_check("busy cmd err STATUS", 3'd0, 8'h19);
        wait_acks(a0 + 1, "busy MEM_RD ack");
        read_check("after busy STATUS", 3'd0, 8'h01);
        read_check("busy write ignored", 3'd1, 8'h00);
        read_check("busy MEM_RD DATA_LO", 3'd3, 8'h57);
        read_check("busy MEM_RD DATA_HI", 3'd4, 8'h13);
        bus_delay = 2;

        // RUN
        dbg_write(3'd0, 8'h02);
        check_bit("RUN CPU_STOP_REQ", CPU_STOP_REQ, 1'b0);
        check_bit("RUN DEBUG_STOP", DEBUG_STOP, 1'b0);
        read_check("RUN STATUS", 3'd0, 8'h00);

        // Reset during a memory transaction
        dbg_write(3'd0, 8'h01);
        wait_debug_stop(1'b1, "pre-reset halt");
        bus_delay = 80;
        a0 = mem_acks;
        dbg_write(3'd0, 8'h05);
        check_bit("pre-reset MEM_REQ", MEM_REQ, 1'b1);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check_bit("reset drops MEM_REQ", MEM_REQ, 1'b0);
        check_bit("reset drops CPU_STOP_REQ", CPU_STOP_REQ, 1'b0);
        check_bit("reset drops DEBUG_STOP", DEBUG_STOP, 1'b0);
        repeat (10) @(negedge CLK);
        check16("abandoned transaction no ack", 16'(mem_acks - a0), 16'd0);
        read_check("post-reset STATUS", 3'd0, 8'h00);
        bus_delay = 2;

`ifdef DEBUG_BREAKPOINT_EN
        // Breakpoint hit, then step off it
        CPU_PC = 16'h0000;
        dbg_write(3'd5, 8'h40);
        dbg_write(3'd6, 8'h80);
        read_check("BP_HI readback", 3'd6, 8'h80);
        check_bit("BP no early hit", DEBUG_STOP, 1'b0);
        CPU_PC = 16'h0040;
        wait_debug_stop(1'b1, "BP halt");
        read_check("BP hit STATUS", 3'd0, 8'h05);
        f0 = stop_falls;
        dbg_write(3'd0, 8'h03);
        wait_debug_stop(1'b1, "BP step re-halt");
        check16("BP step single pulse", 16'(stop_falls - f0), 16'd1);
        read_check("BP step STATUS", 3'd0, 8'h01);
        CPU_PC = 16'h0100;
        dbg_write(3'd0, 8'h02);
        read_check("BP resume STATUS", 3'd0, 8'h00);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
